// File: rtl/oci_mem_access_arbiter.sv
// OCI RAM access arbiter.
// Turns the debug slave's sysclk-domain JTAG memory pulses into one-entry
// queued RAM commands. Shares the single-port OCI RAM round-robin between
// those commands and CPU Avalon-MM accesses, and returns JTAG read data
// through MonDReg / monitor_ready / monitor_error.
module oci_mem_access_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic              cpu_waitrequest,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_readdatavalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD_J = 2'd1,
      ST_RD_C = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   state_t            state_q, state_d;
   logic              last_jtag_q, last_jtag_d;    // 1: JTAG held the last grant
   logic              pend_valid_q, pend_valid_d;
   op_t               pend_op_q, pend_op_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [31:0]       pend_data_q, pend_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       mon_q, mon_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              cpu_rdv_q, cpu_rdv_d;

   logic              cpu_req;
   logic              grant_j;
   logic              grant_c;
   logic              jtag_pulse;
   logic              accept;
   logic              drop;
   logic [ADDR_W-1:0] eff_addr;

   // Only the address and data fields of the payload are meaningful here.
   logic              unused_jdo;
   assign unused_jdo = ^jdo[37:35];

   assign cpu_req    = cpu_read | cpu_write;
   assign jtag_pulse = take_action_ocimem_b | take_no_action_ocimem_a;
   // An address load in the same cycle as a command wins and feeds it.
   assign eff_addr   = take_action_ocimem_a ? jdo[ADDR_W-1:0] : addr_q;
   // A grant of the pending entry frees it in the same cycle.
   assign accept     = jtag_pulse & (~pend_valid_q | grant_j);
   assign drop       = jtag_pulse & ~accept;

   // Round-robin arbitration; grants exist only in IDLE and out of reset.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
      grant_j = 1'b0;
      grant_c = 1'b0;
      if (state_q == ST_IDLE && !reset) begin
         if (pend_valid_q && cpu_req) begin
            grant_j = ~last_jtag_q;
            grant_c = last_jtag_q;
         end else begin
            grant_j = pend_valid_q;
            grant_c = cpu_req;
         end
      end
   end

   // RAM port and CPU handshake follow the winner combinationally.
   always_comb begin
      ram_en          = grant_j | grant_c;
      ram_we          = 1'b0;
      ram_addr        = cpu_address;
      ram_wdata       = cpu_writedata;
      cpu_waitrequest = ~grant_c;
      if (grant_j) begin
         ram_we    = (pend_op_q == OP_WR);
         ram_addr  = pend_addr_q;
         ram_wdata = pend_data_q;
      end else if (grant_c) begin
         ram_we    = cpu_write;
      end
   end

   // FSM next state and round-robin pointer.
   always_comb begin
      state_d     = state_q;
      last_jtag_d = last_jtag_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_j) begin
               last_jtag_d = 1'b1;
               if (pend_op_q == OP_RD) state_d = ST_RD_J;
            end else if (grant_c) begin
               last_jtag_d = 1'b0;
               if (!cpu_write) state_d = ST_RD_C;
            end
         end
         ST_RD_J: state_d = ST_IDLE;
         ST_RD_C: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending buffer, JTAG address pointer, monitor status and read returns.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_op_d    = pend_op_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      addr_d       = eff_addr;
      mon_d        = mon_q;
      ready_d      = ready_q;
      error_d      = (error_q & ~take_action_ocimem_a) | drop;
      cpu_rdata_d  = cpu_rdata_q;
      cpu_rdv_d    = (state_q == ST_RD_C);

      if (grant_j) pend_valid_d = 1'b0;

      if (grant_j && pend_op_q == OP_WR) ready_d = 1'b1;
      if (state_q == ST_RD_J) begin
         mon_d = ram_rdata;
         // A newer command already queued means the last accepted one is not done.
         if (!pend_valid_q) ready_d = 1'b1;
      end
      if (state_q == ST_RD_C) cpu_rdata_d = ram_rdata;

      if (accept) begin
         pend_valid_d = 1'b1;
         pend_op_d    = take_action_ocimem_b ? OP_WR : OP_RD;
         pend_addr_d  = eff_addr;
         pend_data_d  = jdo[34:3];
         addr_d       = eff_addr + ADDR_W'(1);
         ready_d      = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= ST_IDLE;
         last_jtag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_jtag_q <= last_jtag_d;
      end
   end

   // Datapath and output registers; reset discards any queued or in-flight work.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_op_q    <= OP_RD;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         addr_q       <= '0;
         mon_q        <= '0;
         ready_q      <= 1'b0;
         error_q      <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_rdv_q    <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_op_q    <= pend_op_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         addr_q       <= addr_d;
         mon_q        <= mon_d;
         ready_q      <= ready_d;
         error_q      <= error_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rdv_q    <= cpu_rdv_d;
      end
   end

   assign MonDReg           = mon_q;
   assign monitor_ready     = ready_q;
   assign monitor_error     = error_q;
   assign cpu_readdata      = cpu_rdata_q;
   assign cpu_readdatavalid = cpu_rdv_q;

endmodule

// File: tb/tb_oci_mem_access_arbiter.sv
// Directed testbench for oci_mem_access_arbiter with a behavioural
// single-port OCI RAM (1-cycle read latency).
module tb_oci_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  cpu_address;
   logic        cpu_read, cpu_write;
   logic [31:0] cpu_writedata;
   logic        cpu_waitrequest;
   logic [31:0] cpu_readdata;
   logic        cpu_readdatavalid;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   oci_mem_access_arbiter #(.ADDR_W(8)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .cpu_address             (cpu_address),
      .cpu_read                (cpu_read),
      .cpu_write               (cpu_write),
      .cpu_writedata           (cpu_writedata),
      .cpu_waitrequest         (cpu_waitrequest),
      .cpu_readdata            (cpu_readdata),
      .cpu_readdatavalid       (cpu_readdatavalid),
      .ram_en                  (ram_en),
      .ram_we                  (ram_we),
      .ram_addr                (ram_addr),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   // RAM model: unwritten words return a fixed preload pattern.
   logic [31:0] mem [256];
   bit          written [256];

   function automatic logic [31:0] preload(input logic [7:0] a);
      case (a)
         8'h20:   return 32'hCAFEF00D;
         8'h11:   return 32'h0BADF00D;
         8'h12:   return 32'h12121212;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mem_rd(input logic [7:0] a);
      return written[a] ? mem[a] : preload(a);
   endfunction

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
         end else begin
            ram_rdata <= mem_rd(ram_addr);
         end
      end
   end

   // Observation tuple; RAM address/data and read data are masked when not qualified.
   function automatic logic [109:0] pack(input logic w, input logic en, input logic we,
                                         input logic [7:0] a, input logic [31:0] wd,
                                         input logic rdy, input logic err, input logic [31:0] mon,
                                         input logic rdv, input logic [31:0] rd);
      return {w, en, we, (en ? a : 8'h0), ((en && we) ? wd : 32'h0),
              rdy, err, mon, rdv, (rdv ? rd : 32'h0)};
   endfunction

   function automatic logic [109:0] obs();
      return pack(cpu_waitrequest, ram_en, ram_we, ram_addr, ram_wdata,
                  monitor_ready, monitor_error, MonDReg, cpu_readdatavalid, cpu_readdata);
   endfunction

   task automatic check(input string name, input logic [109:0] act, input logic [109:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  j;       // {ocimem_a, ocimem_b, no_action_ocimem_a}
      logic [31:0] jval;    // address for ocimem_a, data for ocimem_b
      logic [1:0]  c;       // {cpu_read, cpu_write}
      logic [7:0]  caddr;
      logic [31:0] cwd;
      logic [2:0]  ectl;    // {waitrequest, ram_en, ram_we}
      logic [7:0]  eaddr;
      logic [31:0] ewd;
      logic [1:0]  est;     // {monitor_ready, monitor_error}
      logic [31:0] emon;
      logic        erdv;
      logic [31:0] erd;
   } vec_t;

   function automatic vec_t mv(input logic [2:0] j, input logic [31:0] jval,
                               input logic [1:0] c, input logic [7:0] caddr, input logic [31:0] cwd,
                               input logic [2:0] ectl, input logic [7:0] eaddr, input logic [31:0] ewd,
                               input logic [1:0] est, input logic [31:0] emon,
                               input logic erdv, input logic [31:0] erd);
      vec_t v;
      v.j = j; v.jval = jval; v.c = c; v.caddr = caddr; v.cwd = cwd;
      v.ectl = ectl; v.eaddr = eaddr; v.ewd = ewd; v.est = est; v.emon = emon;
      v.erdv = erdv; v.erd = erd;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      take_action_ocimem_a    = v.j[2];
      take_action_ocimem_b    = v.j[1];
      take_no_action_ocimem_a = v.j[0];
      jdo           = v.j[2] ? {30'h0, v.jval[7:0]} : {3'b000, v.jval, 3'b000};
      cpu_read      = v.c[1];
      cpu_write     = v.c[0];
      cpu_address   = v.caddr;
      cpu_writedata = v.cwd;
      #1;
      check(name, obs(), pack(v.ectl[2], v.ectl[1], v.ectl[0], v.eaddr, v.ewd,
                              v.est[1], v.est[0], v.emon, v.erdv, v.erd));
   endtask

   task automatic check_word(input string name, input logic [7:0] a, input logic [31:0] exp);
      check(name, {78'h0, mem_rd(a)}, {78'h0, exp});
   endtask

   localparam logic [2:0] JN = 3'b000, JA = 3'b100, JB = 3'b010, JR = 3'b001;
   localparam logic [1:0] CN = 2'b00, CR = 2'b10, CW = 2'b01;
   localparam logic [2:0] NOG = 3'b100, GJW = 3'b111, GJR = 3'b110, GCW = 3'b011, GCR = 3'b010;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];

      reset = 1'b1;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      cpu_read = 1'b1;                 // a request during reset must not be granted
      cpu_address = 8'h10;
      cpu_write = 1'b0;
      cpu_writedata = '0;

      @(negedge clk); #1;
      check("reset_state", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("reset_rdata", {78'h0, cpu_readdata}, 110'h0);
      @(negedge clk);
      cpu_read = 1'b0;
      reset = 1'b0;

      // Contention: JTAG wins the first conflict, then CPU, then JTAG again.
      tbl.push_back(mv(JN|JB, 32'hA5A5A5A5, CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b00, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CR, 8'h20, 0,            GJW, 8'h00, 32'hA5A5A5A5, 2'b00, 0, 0, 0));
      tbl.push_back(mv(JB,    32'h5A5A5A5A, CR, 8'h20, 0,            GCR, 8'h20, 0,            2'b10, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CW, 8'h21, 32'h12345678, NOG, 8'h00, 0,            2'b00, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CW, 8'h21, 32'h12345678, GJW, 8'h01, 32'h5A5A5A5A, 2'b00, 0, 1, 32'hCAFEF00D));
      tbl.push_back(mv(JN,    0,            CW, 8'h21, 32'h12345678, GCW, 8'h21, 32'h12345678, 2'b10, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 0, 0, 0));
      // JTAG write then read-back at 0x10.
      tbl.push_back(mv(JA,    32'h10,       CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 0, 0, 0));
      tbl.push_back(mv(JB,    32'hDEADBEEF, CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            GJW, 8'h10, 32'hDEADBEEF, 2'b00, 0, 0, 0));
      tbl.push_back(mv(JA,    32'h10,       CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 0, 0, 0));
      tbl.push_back(mv(JR,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            GJR, 8'h10, 0,            2'b00, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b00, 0, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 32'hDEADBEEF, 0, 0));
      // Overflow: CPU write stream, second read pulse dropped.
      tbl.push_back(mv(JR,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mv(JR,    0,            CW, 8'h30, 32'h1,        GCW, 8'h30, 32'h1,        2'b00, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mv(JN,    0,            CW, 8'h31, 32'h2,        GJR, 8'h11, 0,            2'b01, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mv(JN,    0,            CW, 8'h31, 32'h2,        NOG, 8'h00, 0,            2'b01, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mv(JN,    0,            CW, 8'h31, 32'h2,        GCW, 8'h31, 32'h2,        2'b11, 32'h0BADF00D, 0, 0));
      tbl.push_back(mv(JR,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b11, 32'h0BADF00D, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            GJR, 8'h12, 0,            2'b01, 32'h0BADF00D, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b01, 32'h0BADF00D, 0, 0));
      tbl.push_back(mv(JA,    32'hFF,       CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b11, 32'h12121212, 0, 0));
      // Address wrap with pulses landing in the grant cycle of the pending entry.
      tbl.push_back(mv(JB,    32'h1,        CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 32'h12121212, 0, 0));
      tbl.push_back(mv(JB,    32'h2,        CN, 8'h00, 0,            GJW, 8'hFF, 32'h1,        2'b00, 32'h12121212, 0, 0));
      tbl.push_back(mv(JB,    32'h3,        CN, 8'h00, 0,            GJW, 8'h00, 32'h2,        2'b00, 32'h12121212, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            GJW, 8'h01, 32'h3,        2'b00, 32'h12121212, 0, 0));
      tbl.push_back(mv(JN,    0,            CN, 8'h00, 0,            NOG, 8'h00, 0,            2'b10, 32'h12121212, 0, 0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      check_word("ram_10", 8'h10, 32'hDEADBEEF);
      check_word("ram_ff", 8'hFF, 32'h1);
      check_word("ram_00", 8'h00, 32'h2);
      check_word("ram_01", 8'h01, 32'h3);
      check_word("ram_21", 8'h21, 32'h12345678);
      check_word("ram_31", 8'h31, 32'h2);

      // Reset during RD_C: no readdatavalid, everything back to reset values.
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 8'h10; #1;
      check("rst_seq_grant", obs(), pack(0, 1, 0, 8'h10, 0, 1, 0, 32'h12121212, 0, 0));
      @(negedge clk);
      cpu_read = 1'b0; reset = 1'b1; #1;
      check("rst_assert", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("rst_assert_rdata", {78'h0, cpu_readdata}, 110'h0);
      @(negedge clk); #1;
      check("rst_hold", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0; cpu_read = 1'b1; cpu_address = 8'h10; #1;
      check("post_rst_grant", obs(), pack(0, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      cpu_read = 1'b0; #1;
      check("post_rst_rdc", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk); #1;
      check("post_rst_rdv", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
      @(negedge clk); #1;
      check("post_rst_rdv_end", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
